newram_arbiter: RTL and testbench

Two-requester arbiter that shares one port of the `newram` frame-buffer RAM between the display scan reader (requester 0) and the host/pixel writer (requester 1). It accepts at most one command per clock and drives registered address, data and write-enable to the RAM. Read data returns to the issuing requester in order, with fixed latency, using an internal tag pipeline. A starvation counter bounds the wait seen by requester 1.

---
 rtl/newram_arbiter.sv | 144 ++++++++++++++
 tb/tb_newram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/newram_arbiter.sv
// Two-requester arbiter for one newram port: registered RAM command, in-order tagged read return.
// Build with NEWRAM_ARB_ROUND_ROBIN_EN defined for alternating grants instead of priority + MAXWAIT guard.
module newram_arbiter #(
    parameter int DATAWIDTH = 256,
    parameter int ADDRWIDTH = 16,
    parameter int LATENCY   = 2,   // must be >= 1
    parameter int MAXWAIT   = 8
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 Req0Valid,
    output logic                 Req0Ready,
    input  logic                 Req0Write,
    input  logic [ADDRWIDTH-1:0] Req0Addr,
    input  logic [DATAWIDTH-1:0] Req0DataIn,
    input  logic                 Req1Valid,
    output logic                 Req1Ready,
    input  logic                 Req1Write,
    input  logic [ADDRWIDTH-1:0] Req1Addr,
    input  logic [DATAWIDTH-1:0] Req1DataIn,
    output logic                 Rsp0Valid,
    output logic [DATAWIDTH-1:0] Rsp0DataOut,
    output logic                 Rsp1Valid,
    output logic [DATAWIDTH-1:0] Rsp1DataOut,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut
);
    logic                 grant0, grant1, xfer, sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_data;

    logic [ADDRWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATAWIDTH-1:0] ram_data_q, ram_data_d;
    logic                 ram_we_q, ram_we_d;

    // Tag stage i belongs to the command issued i clocks ago; stage LATENCY lines up with RamDataOut.
    logic [LATENCY:0]     tag_vld_q, tag_vld_d;
    logic [LATENCY:0]     tag_id_q, tag_id_d;

    logic                 rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
    logic [DATAWIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

`ifdef NEWRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;  // 1 = requester 1 won the most recent transfer

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (ResetN) begin
            if (Req0Valid && Req1Valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = Req0Valid;
                grant1 = Req1Valid;
            end
        end
        last_grant_d = last_grant_q;
        if (grant0 || grant1) last_grant_d = grant1;
    end

    // Reset to "requester 1 last" so requester 0 wins the first contested cycle.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) last_grant_q <= 1'b1;
        else         last_grant_q <= last_grant_d;
    end
`else
    localparam logic [7:0] MAX_WAIT = 8'(MAXWAIT);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (ResetN) begin
            if (Req1Valid && wait_cnt_q == MAX_WAIT) grant1 = 1'b1;
            else if (Req0Valid)                      grant0 = 1'b1;
            else                                     grant1 = Req1Valid;
        end
        wait_cnt_d = wait_cnt_q;
        if (!Req1Valid || grant1)      wait_cnt_d = 8'd0;
        else if (wait_cnt_q != MAX_WAIT) wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) wait_cnt_q <= 8'd0;
        else         wait_cnt_q <= wait_cnt_d;
    end
`endif

    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    always_comb begin
        xfer       = grant0 | grant1;
        sel_write  = grant1 ? Req1Write  : Req0Write;
        sel_addr   = grant1 ? Req1Addr   : Req0Addr;
        sel_data   = grant1 ? Req1DataIn : Req0DataIn;
        ram_we_d   = xfer & sel_write;
        ram_addr_d = xfer ? sel_addr : ram_addr_q;
        ram_data_d = xfer ? sel_data : ram_data_q;

        tag_vld_d  = {tag_vld_q[LATENCY-1:0], xfer & ~sel_write};
        tag_id_d   = {tag_id_q[LATENCY-1:0], grant1};

        rsp0_vld_d  = tag_vld_q[LATENCY] & ~tag_id_q[LATENCY];
        rsp1_vld_d  = tag_vld_q[LATENCY] &  tag_id_q[LATENCY];
        rsp0_data_d = rsp0_vld_d ? RamDataOut : rsp0_data_q;
        rsp1_data_d = rsp1_vld_d ? RamDataOut : rsp1_data_q;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp0_vld_q  <= 1'b0;
            rsp1_vld_q  <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_we_q    <= ram_we_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp0_vld_q  <= rsp0_vld_d;
            rsp1_vld_q  <= rsp1_vld_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign RamAddr        = ram_addr_q;
    assign RamDataIn      = ram_data_q;
    assign RamWriteEnable = ram_we_q;
    assign Rsp0Valid      = rsp0_vld_q;
    assign Rsp1Valid      = rsp1_vld_q;
    assign Rsp0DataOut    = rsp0_data_q;
    assign Rsp1DataOut    = rsp1_data_q;
endmodule

// File: tb/tb_newram_arbiter.sv
// Bench for newram_arbiter: vector table, directed corner sequences and random streams
// scored against a transaction-level model of grants, RAM contents and response timing.
module tb_newram_arbiter;
    localparam int DW  = 256;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int MW  = 8;

    typedef struct { logic v; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { logic id; logic [DW-1:0] data; int due; } exp_t;
    typedef struct { cmd_t c0; cmd_t c1; logic r0; logic r1; } vec_t;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b1;
    logic          Req0Valid = 1'b0, Req0Write = 1'b0, Req1Valid = 1'b0, Req1Write = 1'b0;
    logic [AW-1:0] Req0Addr = '0, Req1Addr = '0;
    logic [DW-1:0] Req0DataIn = '0, Req1DataIn = '0;
    logic          Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RamWriteEnable;
    logic [DW-1:0] Rsp0DataOut, Rsp1DataOut, RamDataIn, RamDataOut;
    logic [AW-1:0] RamAddr;

    always #5 Clk = ~Clk;

    newram_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LATENCY(LAT), .MAXWAIT(MW)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Write(Req0Write),
        .Req0Addr(Req0Addr), .Req0DataIn(Req0DataIn),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Write(Req1Write),
        .Req1Addr(Req1Addr), .Req1DataIn(Req1DataIn),
        .Rsp0Valid(Rsp0Valid), .Rsp0DataOut(Rsp0DataOut),
        .Rsp1Valid(Rsp1Valid), .Rsp1DataOut(Rsp1DataOut),
        .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamWriteEnable(RamWriteEnable),
        .RamDataOut(RamDataOut)
    );

    // RAM stand-in: samples the command each edge, read data emerges LAT edges later.
    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] ram_pipe [0:LAT-1];
    always @(posedge Clk) begin
        if (RamWriteEnable) ram_mem[RamAddr] <= RamDataIn;
        ram_pipe[0] <= ram_mem[RamAddr];
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign RamDataOut = ram_pipe[LAT-1];

    // Transaction-level model
    logic [DW-1:0] mdl_mem [logic [AW-1:0]];
    exp_t          exp_q[$];
    logic [DW-1:0] rsp0_m, rsp1_m, data_m;
    logic [AW-1:0] addr_m;
    logic          we_m, last_m;
    int            denied_m, cyc;

    int            n_chk = 0, n_fail = 0;
    int            n_rsp0 = 0, n_rsp1 = 0, seen0_cyc = -1;
    logic [DW-1:0] rsp0_log[$];
    cmd_t          s0[$], s1[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        cmd_t c;
        c.v = v; c.w = w; c.a = a; c.d = d;
        return c;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : '0;
    endfunction

    function automatic void model_grant(input logic v0, input logic v1, output logic e0, output logic e1);
`ifdef NEWRAM_ARB_ROUND_ROBIN_EN
        if (v0 && v1) begin e0 = last_m; e1 = !last_m; end
        else begin e0 = v0; e1 = v1; end
`else
        e1 = v1 && (!v0 || denied_m >= MW);
        e0 = v0 && !e1;
`endif
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        rsp0_m = '0; rsp1_m = '0; data_m = '0; addr_m = '0; we_m = 1'b0;
        denied_m = 0; last_m = 1'b1;
    endfunction

    task automatic check_outputs();
        logic ev0, ev1;
        ev0 = 1'b0; ev1 = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].id) begin ev1 = 1'b1; rsp1_m = exp_q[0].data; end
            else             begin ev0 = 1'b1; rsp0_m = exp_q[0].data; end
            void'(exp_q.pop_front());
        end
        chk("rsp0_valid", DW'(Rsp0Valid), DW'(ev0));
        chk("rsp1_valid", DW'(Rsp1Valid), DW'(ev1));
        chk("rsp0_data", Rsp0DataOut, rsp0_m);
        chk("rsp1_data", Rsp1DataOut, rsp1_m);
        chk("ram_we", DW'(RamWriteEnable), DW'(we_m));
        chk("ram_addr", DW'(RamAddr), DW'(addr_m));
        chk("ram_data", RamDataIn, data_m);
        if (Rsp0Valid) begin n_rsp0++; seen0_cyc = cyc; rsp0_log.push_back(Rsp0DataOut); end
        if (Rsp1Valid) n_rsp1++;
    endtask

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic step(input cmd_t c0, input cmd_t c1, output logic g0, output logic g1);
        logic e0, e1;
        cmd_t c;
        Req0Valid = c0.v; Req0Write = c0.w; Req0Addr = c0.a; Req0DataIn = c0.d;
        Req1Valid = c1.v; Req1Write = c1.w; Req1Addr = c1.a; Req1DataIn = c1.d;
        #1;
        model_grant(c0.v, c1.v, e0, e1);
        chk("ready0", DW'(Req0Ready), DW'(e0));
        chk("ready1", DW'(Req1Ready), DW'(e1));
        g0 = Req0Ready;
        g1 = Req1Ready;
        @(posedge Clk);
        cyc++;
        we_m = 1'b0;
        if (e0 || e1) begin
            c = e1 ? c1 : c0;
            addr_m = c.a; data_m = c.d; we_m = c.w;
            if (c.w) mdl_mem[c.a] = c.d;
            else exp_q.push_back('{id: e1, data: mdl_rd(c.a), due: cyc + LAT + 1});
            last_m = e1;
        end
        denied_m = (c1.v && !e1) ? denied_m + 1 : 0;
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) step(mk(0, 0, '0, '0), mk(0, 0, '0, '0), g0, g1);
    endtask

    // Reset with both requesters asserting; everything visible must read 0 throughout.
    task automatic do_reset();
        ResetN = 1'b0;
        Req0Valid = 1'b1; Req0Write = 1'b0; Req0Addr = 16'h0123;
        Req1Valid = 1'b1; Req1Write = 1'b1; Req1Addr = 16'h0456; Req1DataIn = rnd_data();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_ready0", DW'(Req0Ready), '0);
            chk("rst_ready1", DW'(Req1Ready), '0);
            chk("rst_ram_we", DW'(RamWriteEnable), '0);
            chk("rst_ram_addr", DW'(RamAddr), '0);
            chk("rst_ram_data", RamDataIn, '0);
            chk("rst_rsp0_valid", DW'(Rsp0Valid), '0);
            chk("rst_rsp1_valid", DW'(Rsp1Valid), '0);
            chk("rst_rsp0_data", Rsp0DataOut, '0);
            chk("rst_rsp1_data", Rsp1DataOut, '0);
            @(posedge Clk);
            @(negedge Clk);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        ResetN = 1'b1;
        model_reset();
    endtask

    // Drains s0/s1; a requester that was refused keeps presenting the same command.
    task automatic run_streams();
        logic g0, g1, pend0, pend1;
        cmd_t c0, c1;
        int   guard;
        pend0 = 1'b0; pend1 = 1'b0; guard = 0;
        while ((s0.size() > 0 || s1.size() > 0) && guard < 400) begin
            c0 = mk(0, 0, '0, '0);
            c1 = mk(0, 0, '0, '0);
            if (s0.size() > 0 && (pend0 || $urandom_range(3) != 0)) c0 = s0[0];
            if (s1.size() > 0 && (pend1 || $urandom_range(3) != 0)) c1 = s1[0];
            step(c0, c1, g0, g1);
            pend0 = c0.v && !g0;
            pend1 = c1.v && !g1;
            if (c0.v && g0) void'(s0.pop_front());
            if (c1.v && g1) void'(s1.pop_front());
            guard++;
        end
        chk("streams_drained", DW'(s0.size() + s1.size()), '0);
        s0.delete();
        s1.delete();
    endtask

    initial begin
        vec_t          tbl[8];
        logic          g0, g1;
        logic [35:0]   g1v, g1e;
        logic [AW-1:0] pool[$];
        int            k, r0_base, r1_base, we_cnt, rdy_cnt;

        model_reset();
        cyc = 0;
        @(negedge Clk);
        do_reset();

        tbl[0] = '{c0: mk(1, 1, 16'h0000, 'h5555), c1: mk(0, 0, '0, '0),          r0: 1, r1: 0};
        tbl[1] = '{c0: mk(0, 0, '0, '0),          c1: mk(1, 1, 16'h0010, 'hA5), r0: 0, r1: 1};
        tbl[2] = '{c0: mk(1, 1, 16'h0020, 'h11),  c1: mk(1, 1, 16'h0030, 'h22), r0: 1, r1: 0};
        tbl[3] = '{c0: mk(0, 0, '0, '0),          c1: mk(1, 1, 16'h0030, 'h22), r0: 0, r1: 1};
        tbl[4] = '{c0: mk(0, 0, '0, '0),          c1: mk(0, 0, '0, '0),          r0: 0, r1: 0};
        tbl[5] = '{c0: mk(1, 0, 16'h0020, '0),    c1: mk(1, 0, 16'h0030, '0),   r0: 1, r1: 0};
        tbl[6] = '{c0: mk(0, 0, '0, '0),          c1: mk(1, 0, 16'h0030, '0),   r0: 0, r1: 1};
        tbl[7] = '{c0: mk(0, 0, '0, '0),          c1: mk(0, 0, '0, '0),          r0: 0, r1: 0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].c0, tbl[i].c1, g0, g1);
            chk($sformatf("vec%0d_r0", i), DW'(g0), DW'(tbl[i].r0));
            chk($sformatf("vec%0d_r1", i), DW'(g1), DW'(tbl[i].r1));
        end
        idle(LAT + 2);

        // Single read: response exactly LATENCY+1 clocks after acceptance, on requester 0 only.
        seen0_cyc = -1;
        r1_base = n_rsp1;
        step(mk(1, 0, 16'h0010, '0), mk(0, 0, '0, '0), g0, g1);
        k = cyc;
        rsp0_log.delete();
        idle(6);
        chk("single_rd_latency", DW'(seen0_cyc - k), DW'(LAT + 1));
        chk("single_rd_count", DW'(rsp0_log.size()), 1);
        chk("single_rd_data", rsp0_log[0], 'hA5);
        chk("single_rd_no_rsp1", DW'(n_rsp1 - r1_base), '0);

        // Read-after-write at the top address, then address 0 to rule out aliasing.
        rsp0_log.delete();
        step(mk(0, 0, '0, '0), mk(1, 1, 16'hFFFF, 'h1234), g0, g1);
        step(mk(1, 0, 16'hFFFF, '0), mk(0, 0, '0, '0), g0, g1);
        step(mk(1, 0, 16'h0000, '0), mk(0, 0, '0, '0), g0, g1);
        idle(LAT + 3);
        chk("raw_count", DW'(rsp0_log.size()), 2);
        chk("raw_top_data", rsp0_log[0], 'h1234);
        chk("raw_zero_data", rsp0_log[1], 'h5555);

        // Contention from a clean reset: both requesters hold Valid every cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s0.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
            s1.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
        end
        for (int i = 0; i < 36; i++) begin
            if (s0.size() < 2) s0.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
            if (s1.size() < 2) s1.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
            step(s0[0], s1[0], g0, g1);
            g1v[i] = g1;
            if (g0) void'(s0.pop_front());
            if (g1) void'(s1.pop_front());
`ifdef NEWRAM_ARB_ROUND_ROBIN_EN
            g1e[i] = (i % 2) == 1;
`else
            g1e[i] = (i % (MW + 1)) == MW;
`endif
        end
        s0.delete();
        s1.delete();
        chk("contention_pattern", DW'(g1v), DW'(g1e));
        idle(2);

        // Interleaved random streams: 20 writes each, then 20 reads each of written addresses.
        for (int i = 0; i < 20; i++) begin
            s0.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
            s1.push_back(mk(1, 1, 16'h0100 | AW'($urandom_range(255)), rnd_data()));
            pool.push_back(s0[i].a);
            pool.push_back(s1[i].a);
        end
        run_streams();
        r0_base = n_rsp0;
        r1_base = n_rsp1;
        for (int i = 0; i < 20; i++) begin
            s0.push_back(mk(1, 0, pool[$urandom_range(39)], '0));
            s1.push_back(mk(1, 0, pool[$urandom_range(39)], '0));
        end
        run_streams();
        idle(LAT + 3);
        chk("stream_rsp0_count", DW'(n_rsp0 - r0_base), 20);
        chk("stream_rsp1_count", DW'(n_rsp1 - r1_base), 20);
        chk("stream_queue_empty", DW'(exp_q.size()), '0);

        // Idle: nothing issued, nothing granted.
        we_cnt = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(mk(0, 0, '0, '0), mk(0, 0, '0, '0), g0, g1);
            if (RamWriteEnable) we_cnt++;
            if (g0 || g1) rdy_cnt++;
        end
        chk("idle_we_cycles", DW'(we_cnt), '0);
        chk("idle_ready_cycles", DW'(rdy_cnt), '0);

        // Reset one cycle after a read is accepted: the read must never answer.
        r0_base = n_rsp0;
        r1_base = n_rsp1;
        step(mk(1, 0, 16'h0010, '0), mk(0, 0, '0, '0), g0, g1);
        chk("midflight_accept", DW'(g0), 1);
        idle(1);
        do_reset();
        idle(LAT + 4);
        chk("midflight_no_rsp", DW'((n_rsp0 - r0_base) + (n_rsp1 - r1_base)), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
